// File: rtl/int_ctrl_pkg.sv
// Shared macros, state encoding and vector address helper for the interrupt sequencer.
`ifndef INT_CTRL_DEFINES
`define INT_CTRL_DEFINES
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ZERO
`define ZERO 32'h0000_0000
`endif
`ifndef STOP
`define STOP 1'b1
`endif
`define INT_VECTOR_BASE   32'h0000_0100
`define INT_VECTOR_STRIDE 32'h0000_0010
`define INT_IDLE    2'b00
`define INT_ARM     2'b01
`define INT_TAKE    2'b10
`define INT_SERVICE 2'b11
`endif

package int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = `INT_IDLE,
        ST_ARM     = `INT_ARM,
        ST_TAKE    = `INT_TAKE,
        ST_SERVICE = `INT_SERVICE
    } int_state_e;

    localparam int STALL_WIDTH = 6;

    // Vector arithmetic deliberately wraps at the address width.
    function automatic logic [`ADDR_WIDTH-1:0] vector_addr(
        input logic [`ADDR_WIDTH-1:0] base,
        input logic [`ADDR_WIDTH-1:0] stride,
        input logic [31:0]            idx
    );
        return base + stride * `ADDR_WIDTH'(idx);
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder: index of the first set request plus a valid flag.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt sequencer: latches irq edges, picks one by fixed priority, waits for a
// safe pipeline slot, pulses int_enable_o with the ISR vector and blocks until mret.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int                     NUM_IRQ       = 4,
    parameter logic [`ADDR_WIDTH-1:0] VECTOR_BASE   = `INT_VECTOR_BASE,
    parameter logic [`ADDR_WIDTH-1:0] VECTOR_STRIDE = `INT_VECTOR_STRIDE,
    localparam int                    CW            = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_IRQ-1:0]     irq_i,
    input  logic [NUM_IRQ-1:0]     irq_mask_i,
    input  logic                   gie_i,
    input  logic [STALL_WIDTH-1:0] stall_i,
    input  logic                   jump_enable_i,
    input  logic                   mret_i,
    input  logic [`ADDR_WIDTH-1:0] resume_pc_i,
    output logic                   int_enable_o,
    output logic [`ADDR_WIDTH-1:0] isr_addr_o,
    output logic [`ADDR_WIDTH-1:0] epc_o,
    output logic [CW-1:0]          int_cause_o,
    output logic                   in_service_o,
    output logic [NUM_IRQ-1:0]     pending_o
);

    int_state_e             state_q;
    logic [CW-1:0]          sel_cause_q;
    logic                   int_enable_q;
    logic [`ADDR_WIDTH-1:0] isr_addr_q;
    logic [`ADDR_WIDTH-1:0] epc_q;
    logic [CW-1:0]          int_cause_q;
    logic                   in_service_q;

    logic [NUM_IRQ-1:0] irq_d_q, irq_d_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] rise, clr, eligible;
    logic [CW-1:0]      sel_idx;
    logic               sel_valid;
    logic               safe_slot;
    logic               abort_arm;

    // A fresh rise always sets its bit, even on the cycle that bit is being cleared.
    always_comb begin
        irq_d_d = irq_i;
        rise    = irq_i & ~irq_d_q;
        clr     = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if ((state_q == ST_TAKE) && (sel_cause_q == CW'(i))) begin
                clr[i] = 1'b1;
            end
        end
        pending_d = (pending_q & ~clr) | rise;
        eligible  = gie_i ? (pending_q & irq_mask_i) : '0;
        safe_slot = (stall_i == '0) && !jump_enable_i;
        abort_arm = !gie_i || !irq_mask_i[sel_cause_q];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_d_q   <= '0;
            pending_q <= '0;
        end else begin
            irq_d_q   <= irq_d_d;
            pending_q <= pending_d;
        end
    end

    int_prio_enc #(
        .N  (NUM_IRQ),
        .IW (CW)
    ) u_prio_enc (
        .req_i   (eligible),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    // Losing the mask or gie while armed wins over a coincident safe slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            sel_cause_q  <= '0;
            int_enable_q <= 1'b0;
            isr_addr_q   <= `ZERO;
            epc_q        <= `ZERO;
            int_cause_q  <= '0;
            in_service_q <= 1'b0;
        end else begin
            int_enable_q <= 1'b0;
            isr_addr_q   <= `ZERO;
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        sel_cause_q <= sel_idx;
                        state_q     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (abort_arm) begin
                        state_q <= ST_IDLE;
                    end else if (safe_slot) begin
                        state_q      <= ST_TAKE;
                        epc_q        <= resume_pc_i;
                        int_cause_q  <= sel_cause_q;
                        int_enable_q <= 1'b1;
                        isr_addr_q   <= vector_addr(VECTOR_BASE, VECTOR_STRIDE, 32'(sel_cause_q));
                        in_service_q <= 1'b1;
                    end
                end
                ST_TAKE: begin
                    state_q <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    if (mret_i) begin
                        in_service_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign int_enable_o = int_enable_q;
    assign isr_addr_o   = isr_addr_q;
    assign epc_o        = epc_q;
    assign int_cause_o  = int_cause_q;
    assign in_service_o = in_service_q;
    assign pending_o    = pending_q;

endmodule
